cv32e40p_ft_reconfig_ctrl: RTL and testbench

CV32E40P_FT_RECONFIG_CTRL -- requirements
Module: cv32e40p_ft_reconfig_ctrl

---
 rtl/cv32e40p_pkg.sv | 22 ++
 rtl/cv32e40p_ft_err_counter.sv | 52 +++++
 rtl/cv32e40p_ft_reconfig_ctrl.sv | 109 ++++++++++
 tb/tb_cv32e40p_ft_reconfig_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and defaults for the fault-tolerant replica reconfiguration logic.
// Holds the reconfiguration FSM state type and the default leaky-bucket tuning.
package cv32e40p_pkg;

   typedef enum logic [1:0] {
      MONITOR  = 2'd0,
      DRAIN    = 2'd1,
      SWAP     = 2'd2,
      DEGRADED = 2'd3
   } ft_state_e;

   localparam int FT_THRESH_DEFAULT = 100;
   localparam int FT_DECAY_DEFAULT  = 2;

   // Lowest-index pending slot wins; callers only use the result when p != 0.
   function automatic logic [1:0] lowest_pending(input logic [2:0] p);
      if (p[0])      return 2'd0;
      else if (p[1]) return 2'd1;
      else           return 2'd2;
   endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// Leaky-bucket error counter for one voter slot with a sticky over-threshold flag.
// Count and flag update on the same edge; pending_nxt exposes the flag one cycle early.
module cv32e40p_ft_err_counter
   import cv32e40p_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int THRESH = FT_THRESH_DEFAULT,
   parameter int DECAY  = FT_DECAY_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             valid,
   input  logic             err,
   output logic [CNT_W-1:0] count,
   output logic             pending,
   output logic             pending_nxt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEC     = CNT_W'(DECAY);
   localparam logic [31:0]      THR32   = 32'(THRESH);

   logic [CNT_W-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (clr) begin
         count_nxt = '0;
      end else if (valid) begin
         if (err)
            count_nxt = (count == CNT_MAX) ? count : count + ONE;
         else
            count_nxt = (count > DEC) ? count - DEC : '0;
      end
   end

   // The compare is widened so a THRESH beyond the counter range simply never fires.
   assign pending_nxt = !clr && (pending || (32'(count_nxt) > THR32));

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         pending <= 1'b0;
      end else begin
         count   <= count_nxt;
         pending <= pending_nxt;
      end
   end

endmodule

// File: rtl/cv32e40p_ft_reconfig_ctrl.sv
// Swaps a persistently failing TMR replica for the spare after draining EX, else goes fatal.
// Stall one cycle after the crossing edge, swap outputs two cycles after when EX is idle.
module cv32e40p_ft_reconfig_ctrl
   import cv32e40p_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int THRESH = FT_THRESH_DEFAULT,
   parameter int DECAY  = FT_DECAY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [2:0] err_detected_i,
   input  logic       ex_idle_i,
   output logic [2:0] sel_mux_o,
   output logic [3:0] clock_en_o,
   output logic [3:0] permanent_faulty_o,
   output logic       fault_event_o,
   output logic       stall_o,
   output logic       fatal_o
);

   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       pend;
   logic [2:0]       pend_nxt;
   logic [2:0]       clr;
   ft_state_e        state;
   logic [1:0]       slot;
   logic [1:0]       lp;
   logic             spare_used;

   for (genvar g = 0; g < 3; g++) begin : g_cnt
      cv32e40p_ft_err_counter #(
         .CNT_W  (CNT_W),
         .THRESH (THRESH),
         .DECAY  (DECAY)
      ) u_cnt (
         .clk         (clk),
         .rst         (rst),
         .clr         (clr[g]),
         .valid       (valid_i),
         .err         (err_detected_i[g]),
         .count       (cnt[g]),
         .pending     (pend[g]),
         .pending_nxt (pend_nxt[g])
      );
   end

   assign lp = lowest_pending(pend_nxt);

   // The swapped slot's counter restarts from zero and from then on watches the spare.
   always_comb begin
      clr = '0;
      if (state == SWAP)
         clr[slot] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= MONITOR;
         slot               <= 2'd0;
         spare_used         <= 1'b0;
         sel_mux_o          <= 3'b111;
         clock_en_o         <= 4'b0111;
         permanent_faulty_o <= 4'b0000;
         fault_event_o      <= 1'b0;
         stall_o            <= 1'b0;
         fatal_o            <= 1'b0;
      end else begin
         fault_event_o <= 1'b0;
         case (state)
            MONITOR: begin
               // React to the flag being set this edge so the stall lands one cycle after crossing.
               if (|pend_nxt) begin
                  slot <= lp;
                  if (!spare_used) begin
                     state   <= DRAIN;
                     stall_o <= 1'b1;
                  end else begin
                     state   <= DEGRADED;
                     fatal_o <= 1'b1;
                     permanent_faulty_o[sel_mux_o[lp] ? lp : 2'd3] <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (ex_idle_i) begin
                  state   <= SWAP;
                  stall_o <= 1'b0;
               end
            end
            SWAP: begin
               sel_mux_o[slot]          <= 1'b0;
               clock_en_o[slot]         <= 1'b0;
               clock_en_o[3]            <= 1'b1;
               permanent_faulty_o[slot] <= 1'b1;
               spare_used               <= 1'b1;
               fault_event_o            <= 1'b1;
               state                    <= MONITOR;
            end
            DEGRADED: begin
               state <= DEGRADED;
            end
            default: state <= MONITOR;
         endcase
      end
   end

endmodule

// File: tb/tb_cv32e40p_ft_reconfig_ctrl.sv
// Directed bench for the replica reconfiguration controller: vector table plus corner sequences.
module tb_cv32e40p_ft_reconfig_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_i;
   logic [2:0] err_detected_i;
   logic       ex_idle_i;
   logic [2:0] sel_mux_o;
   logic [3:0] clock_en_o;
   logic [3:0] permanent_faulty_o;
   logic       fault_event_o;
   logic       stall_o;
   logic       fatal_o;

   int pass_cnt = 0;
   int total    = 0;

   cv32e40p_ft_reconfig_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .valid_i            (valid_i),
      .err_detected_i     (err_detected_i),
      .ex_idle_i          (ex_idle_i),
      .sel_mux_o          (sel_mux_o),
      .clock_en_o         (clock_en_o),
      .permanent_faulty_o (permanent_faulty_o),
      .fault_event_o      (fault_event_o),
      .stall_o            (stall_o),
      .fatal_o            (fatal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         reps;
      logic       rst;
      logic       valid;
      logic [2:0] err;
      logic       idle;
      logic [2:0] sel;
      logic [3:0] ce;
      logic [3:0] pf;
      logic       fe;
      logic       stall;
      logic       fatal;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic v, input logic [2:0] e, input logic i);
      rst = r;
      valid_i = v;
      err_detected_i = e;
      ex_idle_i = i;
   endtask

   function automatic logic [13:0] outs();
      return {sel_mux_o, clock_en_o, permanent_faulty_o, fault_event_o, stall_o, fatal_o};
   endfunction

   localparam logic [13:0] RST_OUTS = {3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};

   initial begin
      int cmax;
      int stall_seen;
      int bad;

      // reps, rst, valid, err, idle | sel, clock_en, perm_faulty, fault_event, stall, fatal
      vecs[0]  = '{2,   1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{100, 1'b0, 1'b1, 3'b010, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1,   1'b0, 1'b1, 3'b010, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1,   1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1,   1'b0, 1'b0, 3'b000, 1'b1, 3'b101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1,   1'b0, 1'b0, 3'b000, 1'b1, 3'b101, 4'b1101, 4'b0010, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{200, 1'b0, 1'b0, 3'b111, 1'b1, 3'b101, 4'b1101, 4'b0010, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1,   1'b1, 1'b0, 3'b000, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{100, 1'b0, 1'b1, 3'b101, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1,   1'b0, 1'b1, 3'b101, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1,   1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1,   1'b0, 1'b0, 3'b000, 1'b1, 3'b110, 4'b1110, 4'b0001, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1,   1'b0, 1'b0, 3'b000, 1'b1, 3'b110, 4'b1110, 4'b0101, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{50,  1'b0, 1'b1, 3'b111, 1'b1, 3'b110, 4'b1110, 4'b0101, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{1,   1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{101, 1'b0, 1'b1, 3'b001, 1'b0, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{1,   1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1,   1'b0, 1'b0, 3'b000, 1'b0, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{3,   1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0};

      drive(1'b1, 1'b0, 3'b000, 1'b1);
      @(negedge clk);

      for (int v = 0; v < NV; v++) begin
         drive(vecs[v].rst, vecs[v].valid, vecs[v].err, vecs[v].idle);
         for (int r = 0; r < vecs[v].reps; r++) step();
         chk($sformatf("vec%0d", v), 32'(outs()),
             32'({vecs[v].sel, vecs[v].ce, vecs[v].pf, vecs[v].fe, vecs[v].stall, vecs[v].fatal}));
      end

      // Alternating errors on slot 0 must never accumulate.
      drive(1'b1, 1'b0, 3'b000, 1'b1);
      step();
      rst = 1'b0;
      cmax = 0;
      stall_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         valid_i = 1'b1;
         err_detected_i = {2'b00, (i % 2) == 0};
         step();
         if (int'(dut.cnt[0]) > cmax) cmax = int'(dut.cnt[0]);
         if (stall_o) stall_seen++;
      end
      chk("alt_cnt0_max", 32'(cmax), 32'd1);
      chk("alt_no_stall", 32'(stall_seen), 32'd0);
      chk("alt_outputs", 32'(outs()), 32'(RST_OUTS));

      // Errors without valid must leave every counter at zero.
      drive(1'b1, 1'b0, 3'b000, 1'b1);
      step();
      drive(1'b0, 1'b0, 3'b111, 1'b1);
      for (int i = 0; i < 200; i++) step();
      for (int k = 0; k < 3; k++)
         chk($sformatf("novalid_cnt%0d", k), 32'(dut.cnt[k]), 32'd0);

      // Drain held by a busy EX: stall for 20 cycles, no swap until EX is idle.
      drive(1'b1, 1'b0, 3'b000, 1'b0);
      step();
      drive(1'b0, 1'b1, 3'b010, 1'b0);
      for (int i = 0; i < 101; i++) step();
      valid_i = 1'b0;
      err_detected_i = 3'b000;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (!(stall_o && sel_mux_o == 3'b111 && !fault_event_o && clock_en_o == 4'b0111)) bad++;
         if (c == 19) ex_idle_i = 1'b1;
         step();
      end
      chk("drain_hold_cycles_bad", 32'(bad), 32'd0);
      chk("drain_exit_swap_state", 32'(outs()), 32'(RST_OUTS));
      step();
      chk("drain_swap_done", 32'(outs()),
          32'({3'b101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0}));
      step();
      chk("drain_event_one_cycle", 32'(fault_event_o), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
